// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit arbiter.
//   - Arbiter FSM state encodings, as localparams and as an enum type.
//   - Default byte width and default watchdog limit for the arbiter.
package uart_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 20000;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_START_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_START = ST_START_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_DONE  = ST_DONE_ENC
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
// Combinational round-robin selector. The search starts one position after
// the last granted requester and wraps around, so the last winner has the
// lowest priority.
// Ports:
//   req_i    in   NUM_REQ  request vector (holdoff mask already applied)
//   last_i   in   IDX_W    index of the previously granted requester
//   valid_o  out  1        at least one request bit is set
//   idx_o    out  IDX_W    index of the selected requester
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Walk the candidates in priority order; the first set bit wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        cand  = '0;
        idx_o = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_i) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter among NUM_REQ
// byte producers. A granted byte is latched, a start pulse goes to the
// UART, and the requester gets an ack pulse on tx_done or an err pulse when
// the watchdog expires.
// Ports:
//   clk       in   1               system clock
//   rst       in   1               asynchronous active-low reset
//   req       in   NUM_REQ         level requests, held until ack/err
//   req_data  in   NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//   ack       out  NUM_REQ         one-cycle completion pulse
//   err       out  NUM_REQ         one-cycle timeout pulse
//   tx_start  out  1               one-cycle start pulse to the UART
//   tx_data   out  DATA_W          byte being sent
//   tx_done   in   1               UART completion; rising edge only
//   busy      out  1               FSM is not idle
//   grant_id  out  clog2(NUM_REQ)  current or last granted requester
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [NUM_REQ-1:0]          err,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_done,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [NUM_REQ-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 tx_done_q;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic                 done_edge;

    // The mask hides the just-served requester for one IDLE cycle so it has
    // time to drop its request before it could be granted again.
    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req & ~mask_q),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // tx_done_q runs in every state, so a level already high when WAIT is
    // entered does not look like a fresh edge.
    assign done_edge = tx_done & ~tx_done_q;

    // Next-state and next-output logic. Outputs are computed one cycle early
    // and registered, so nothing combinational reaches the ports.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        err_d   = '0;
        start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                mask_d = '0;
                if (pick_valid) begin
                    grant_d = pick_idx;
                    data_d  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion edge beats a coincident timeout.
                if (done_edge) begin
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    err_d[grant_q] = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                last_d          = grant_q;
                mask_d          = '0;
                mask_d[grant_q] = 1'b1;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset also forces the UART-facing outputs
    // low so a reset mid-transfer leaves nothing pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            data_q    <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign tx_start = start_q;
    assign tx_data  = data_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule
